// File: rtl/muxn_arb_pkg.sv
// Shared constants for the muxn_arb registered N-channel multiplexer.
package muxn_pkg;

   typedef enum logic {
      MODE_SELECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   localparam int CHANNELS_MIN = 2;
   localparam int CHANNELS_MAX = 16;

endpackage

// File: rtl/muxn_arb_rr.sv
// Combinational rotate-priority arbiter: highest priority is the channel after last_grant.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [N-1:0] grant_oh,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid
);

   logic [2*N-1:0] req2;
   logic [N-1:0]   rot;
   int unsigned    base;
   int unsigned    pos;

   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      pos         = 0;
      base        = (32'(last_grant) + 1) % N;
      // Rotate so the preferred channel lands at bit 0, then pick the lowest set bit.
      req2 = {req, req} >> base;
      rot  = req2[N-1:0];
      for (int unsigned j = 0; j < N; j++) begin
         if (rot[j] && !grant_valid) begin
            grant_valid = 1'b1;
            pos         = (base + j) % N;
         end
      end
      if (grant_valid) begin
         grant_idx      = W'(pos);
         grant_oh[pos]  = 1'b1;
      end
   end

endmodule

// File: rtl/muxn_arb.sv
// N-channel registered mux with valid/ready, explicit select or round-robin.
// Round-robin mode is built only when MUXN_ARB_RR_EN is defined.
module muxn_arb
   import muxn_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          choose,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      sel_error
);

   if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
      $error("muxn_arb: CHANNELS out of legal range");
   end

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic [SEL_W-1:0]    out_chan_q, out_chan_d;
   logic [SEL_W-1:0]    last_grant_q, last_grant_d;
   logic                sel_error_q, sel_error_d;

   logic                load_en, grant_valid, range_ok, rr_mode, xfer;
   logic [SEL_W-1:0]    grant;
   logic [CHANNELS-1:0] grant_oh;
   logic [WIDTH-1:0]    chan_data [CHANNELS];
   logic [CHANNELS-1:0] rr_oh;
   logic [SEL_W-1:0]    rr_idx;
   logic                rr_valid;

`ifdef MUXN_ARB_RR_EN
   rr_arbiter #(.N(CHANNELS)) u_rr_arbiter (
      .req         (in_valid),
      .last_grant  (last_grant_q),
      .grant_oh    (rr_oh),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   always_comb rr_mode = (mode == MODE_RR);
`else
   logic unused_mode;

   always_comb begin
      unused_mode = mode;
      rr_mode     = 1'b0;
      rr_oh       = '0;
      rr_idx      = '0;
      rr_valid    = 1'b0;
   end
`endif

   if ((1 << SEL_W) == CHANNELS) begin : g_pow2
      always_comb range_ok = 1'b1;
   end else begin : g_npow2
      localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);
      always_comb range_ok = ({1'b0, choose} < CH_LIM);
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         chan_data[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      load_en  = !out_valid_q || out_ready;
      grant_oh = '0;
      if (rr_mode) begin
         grant       = rr_idx;
         grant_valid = rr_valid;
         grant_oh    = rr_oh;
      end else begin
         // Out-of-range choose keeps pointing at the previous winner.
         grant           = range_ok ? choose : last_grant_q;
         grant_valid     = 1'b1;
         grant_oh[grant] = 1'b1;
      end

      in_ready = (load_en && grant_valid && !reset) ? grant_oh : '0;
      xfer     = in_valid[grant] && in_ready[grant];

      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      last_grant_d = last_grant_q;
      sel_error_d  = !rr_mode && !range_ok;
      if (xfer) begin
         out_valid_d  = 1'b1;
         out_data_d   = chan_data[grant];
         out_chan_d   = grant;
         last_grant_d = grant;
      end else if (load_en) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_chan_q   <= '0;
         last_grant_q <= SEL_W'(CHANNELS - 1);
         sel_error_q  <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         last_grant_q <= last_grant_d;
         sel_error_q  <= sel_error_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign sel_error = sel_error_q;

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb with a queue-based reference model (5 channels).
module tb_muxn_arb;

   localparam int CH    = 5;
   localparam int W     = 32;
   localparam int SW    = $clog2(CH);
`ifdef MUXN_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            mode;
   logic [SW-1:0]   choose;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [CH*W-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_chan;
   logic            sel_error;

   muxn_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .choose    (choose),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .sel_error (sel_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] chan;
   } beat_t;

   beat_t sb[$];
   int    checks   = 0;
   int    failures = 0;

   // Reference state: what the output register should hold.
   bit           m_ov   = 1'b0;
   logic [W-1:0] m_data = '0;
   int           m_chan = 0;
   int           m_last = CH - 1;
   bit           m_sel  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid === 1'b1 && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(out_chan), 32'hFFFF_FFFF);
         end else begin
            beat_t b;
            b = sb.pop_front();
            chk("sb_data", out_data, b.data);
            chk("sb_chan", 32'(out_chan), 32'(b.chan));
         end
      end
   end

   task automatic step();
      bit            eff_rr, load, gv;
      int            g, c;
      logic [CH-1:0] exp_rdy;
      @(negedge clk);
      eff_rr = RR_EN && mode;
      load   = !m_ov || out_ready;
      gv     = 1'b0;
      g      = 0;
      if (eff_rr) begin
         for (int k = 1; k <= CH; k++) begin
            c = (m_last + k) % CH;
            if (!gv && in_valid[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end else begin
         gv = 1'b1;
         g  = (int'(choose) < CH) ? int'(choose) : m_last;
      end
      exp_rdy = '0;
      if (!reset && load && gv) exp_rdy[g] = 1'b1;

      chk("in_ready",  32'(in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("sel_error", 32'(sel_error), 32'(m_sel));
      chk("out_data",  out_data,       m_data);
      chk("out_chan",  32'(out_chan),  32'(m_chan));

      if (reset) begin
         m_ov = 1'b0; m_data = '0; m_chan = 0; m_last = CH - 1; m_sel = 1'b0;
         sb.delete();
      end else begin
         m_sel = !eff_rr && (int'(choose) >= CH);
         if (exp_rdy != '0 && in_valid[g]) begin
            m_ov   = 1'b1;
            m_data = in_data[g*W +: W];
            m_chan = g;
            m_last = g;
            sb.push_back('{data: in_data[g*W +: W], chan: SW'(g)});
         end else if (load) begin
            m_ov = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < CH; i++) in_data[i*W +: W] = $urandom;
   endtask

   initial begin
      reset = 1'b1; mode = 1'b0; choose = '0; in_valid = '0;
      in_data = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      step(); step();
      reset = 1'b0;

      // Explicit select of channel 2.
      rand_data();
      choose = 3'd2; in_valid = 5'b00100; in_data[2*W +: W] = 32'hDEAD_BEEF;
      step();
      in_valid = '0; step();

      // Out-of-range choose re-grants the last channel and flags sel_error once.
      choose = 3'd1; in_valid = 5'b00010; rand_data(); step();
      choose = 3'd6; rand_data(); step();
      choose = 3'd1; in_valid = '0; step(); step();

      // Round-robin with every channel valid, starting from reset.
      reset = 1'b1; step(); reset = 1'b0;
      mode = 1'b1; in_valid = '1;
      for (int i = 0; i < 2 * CH; i++) begin rand_data(); step(); end

      // Sparse requests: only channels 1 and 3.
      in_valid = 5'b01010;
      for (int i = 0; i < 4; i++) begin rand_data(); step(); end

      // Backpressure with changing inputs, then release.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = CH'($urandom); choose = SW'($urandom); rand_data(); step();
      end
      out_ready = 1'b1; in_valid = '1; step();

      // Reset while holding data, then round-robin restarts at channel 0.
      out_ready = 1'b0; step();
      reset = 1'b1; step(); reset = 1'b0;
      out_ready = 1'b1; step(); in_valid = '0; step();

      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 63) == 0);
         mode      = $urandom_range(0, 1) == 1;
         choose    = SW'($urandom_range(0, 7));
         in_valid  = CH'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         rand_data();
         step();
      end

      reset = 1'b0; out_ready = 1'b1; in_valid = '0;
      step(); step(); step();
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-channel, width-generic registered multiplexer with valid/ready handshaking. It is the successor to the fixed 3-input combinational datapath mux. It selects one of `CHANNELS` producers either by an explicit `choose` index or by round-robin arbitration, and drives one registered output stage. It sits between multiple datapath producers (ALU result, memory read data, PC+4, forwarding paths, bus masters) and a single consumer in the MIPS pipeline or memory interface.

## Interface
- `WIDTH`, 32: data width per channel.
- `CHANNELS`, 4: number of input channels, legal range 2..16.
- `SEL_W`, `$clog2(CHANNELS)`: select/channel-index width (localparam, not overridable).

- `clk`  in  1  system clock. One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = SELECT (use `choose`), 1 = ROUND_ROBIN.
- `choose`  in  SEL_W  explicit channel index, used in SELECT mode.
- `in_valid`  in  CHANNELS  per-channel data valid.
- `in_ready`  out  CHANNELS  per-channel accept.
- `in_data`  in  CHANNELS*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- `out_valid`  out  1  output register holds data.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  WIDTH  registered selected data.
- `out_chan`  out  SEL_W  index of the channel that supplied `out_data`.
- `sel_error`  out  1  one-cycle pulse for an out-of-range `choose`.

## Operation
- `load_en = !out_valid || out_ready`. The output register can accept whenever it is empty or draining this cycle.
- `grant` is computed combinationally each cycle:
  - SELECT mode:
    - `grant = choose` if `choose < CHANNELS`.
    - Otherwise `grant = last_grant`, which holds the most recent choice.
  - ROUND_ROBIN mode:
    - The search starts at `last_grant+1`, wraps modulo `CHANNELS`, and picks the first channel with `in_valid` high.
    - If no channel is valid, nothing is granted.
- `in_ready[i] = load_en && grant_valid && (grant == i)`. At most one `in_ready` bit is high.
- A transfer occurs when `in_valid[grant] && in_ready[grant]`. On a transfer:
  - `out_data` ← `in_data[grant]`.
  - `out_chan` ← `grant`.
  - `out_valid` ← 1.
  - `last_grant` ← `grant`.
- If `load_en` is high and no transfer occurs, `out_valid` ← 0.
- `sel_error` is registered. It is 1 in the cycle after any cycle with `mode==0 && choose >= CHANNELS`, independent of `in_valid`. It is never asserted in ROUND_ROBIN mode.
- `mode` and `choose` are sampled combinationally every cycle. A change affects the next grant, and data already held in the output register is unaffected.
- When `CHANNELS` is a power of two, `choose` can never be out of range and `sel_error` is constant 0.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_chan=0`, `sel_error=0`.
  - `last_grant=CHANNELS-1`, so the first round-robin grant starts at channel 0.
- Reset asserted mid-operation discards held data. `in_ready` is 0 in every reset cycle.
- Latency is 1 cycle from input transfer to `out_valid`. Sustained throughput is 1 transfer per cycle while `out_ready=1`.
- `in_ready` depends combinationally on `out_ready`. There is no skid buffer.
- If `out_valid=1` and `out_ready=0`, then:
  - `out_data` and `out_chan` are held stable.
  - All `in_ready` bits are 0.
- In round-robin mode with all channels continuously valid, each channel is granted exactly once every `CHANNELS` transfers.

## Configuration
- `MUXN_ARB_RR_EN` defined: the ROUND_ROBIN mode is built and the `rr_arbiter` instance is present.
- `MUXN_ARB_RR_EN` undefined:
  - The `mode` port remains but is ignored, and the block always operates in SELECT mode.
  - No arbiter logic is generated.
  - `last_grant` still tracks the most recent grant for the out-of-range hold behaviour.

## Structure
- Package `muxn_pkg` holds the mode constants `MODE_SELECT=1'b0` and `MODE_RR=1'b1`, plus the `CHANNELS` legal-range limits.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant, encoded grant index, `grant_valid`.
  - Purely combinational, with a rotate-priority implementation.
- The top-level `muxn_arb` owns the output register, `last_grant`, and `sel_error`.

## Test plan
- Reset release, SELECT mode, `choose=2`, `in_valid=4'b0100`, `in_data[2]=32'hDEAD_BEEF`, `out_ready=1` → next cycle `out_valid=1`, `out_data=DEADBEEF`, `out_chan=2`.
- `CHANNELS=3`, transfer on channel 1, then `choose=3` with `in_valid[1]=1` → channel 1 is re-granted, `sel_error=1` for exactly one cycle, then returns to 0 after `choose` returns in range.
- ROUND_ROBIN mode, all four `in_valid=1`, `out_ready=1` for 8 cycles → `out_chan` sequence is 0,1,2,3,0,1,2,3.
- ROUND_ROBIN mode, `in_valid=4'b1010`, last grant 1 → next grant is 3, then 1. Channels 0 and 2 never see `in_ready`.
- Backpressure: `out_valid=1`, `out_ready=0` for 3 cycles with inputs changing → `out_data` and `out_chan` stable, all `in_ready=0`. Deassert backpressure → the queued grant transfers in the same cycle.
- Reset asserted while `out_valid=1` → next cycle `out_valid=0`, `out_data=0`, `out_chan=0`. The first round-robin grant afterwards is channel 0.
